// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared opcodes, stats width, FSM encoding and response record for alu_arbiter
package alu_arb_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    localparam int STAT_W = 16;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic        ne;
        logic        lt;
        logic        ovf;
    } resp_t;

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// rr_grant2: two-way round-robin grant, gated by response-slot availability
module rr_grant2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic slot_free,
    output logic grant_valid,
    output logic grant_id
);

    // on a tie the requester that did not win last time goes next
    always_comb begin
        grant_valid = slot_free && (valid0 || valid1);
        grant_id    = (valid0 && valid1) ? ~last_grant : valid1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of the ALU between execute (0) and multdiv (1); optional grant stats via ALU_ARB_STATS_EN
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [31:0]       req0_operandA,
    input  logic [31:0]       req0_operandB,
    input  logic [4:0]        req0_opcode,
    input  logic [4:0]        req0_shamt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [31:0]       req1_operandA,
    input  logic [31:0]       req1_operandB,
    input  logic [4:0]        req1_opcode,
    input  logic [4:0]        req1_shamt,
    output logic [31:0]       alu_operandA,
    output logic [31:0]       alu_operandB,
    output logic [4:0]        alu_opcode,
    output logic [4:0]        alu_shamt,
    input  logic [31:0]       alu_result,
    input  logic              alu_isNotEqual,
    input  logic              alu_isLessThan,
    input  logic              alu_overflow,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [31:0]       resp_result,
    output logic              resp_isNotEqual,
    output logic              resp_isLessThan,
    output logic              resp_overflow,
    output logic [STAT_W-1:0] stat_grants0,
    output logic [STAT_W-1:0] stat_grants1
);

    logic [0:0] state_q, state_d;
    resp_t      resp_q, resp_d;
    logic       last_q, last_d;
    logic       slot_free, grant_valid, grant_id;

    rr_grant2 u_grant (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_q),
        .slot_free   (slot_free),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // handshake, ALU operand steering and response outputs
    always_comb begin
        resp_valid      = (state_q == ST_FULL);
        slot_free       = !resp_valid || resp_ready;
        req0_ready      = grant_valid && !grant_id;
        req1_ready      = grant_valid && grant_id;
        alu_operandA    = grant_valid ? (grant_id ? req1_operandA : req0_operandA) : 32'd0;
        alu_operandB    = grant_valid ? (grant_id ? req1_operandB : req0_operandB) : 32'd0;
        alu_opcode      = grant_valid ? (grant_id ? req1_opcode : req0_opcode) : OP_ADD;
        alu_shamt       = grant_valid ? (grant_id ? req1_shamt : req0_shamt) : 5'd0;
        resp_id         = resp_q.id;
        resp_result     = resp_q.result;
        resp_isNotEqual = resp_q.ne;
        resp_isLessThan = resp_q.lt;
        resp_overflow   = resp_q.ovf;
    end

    // EMPTY/FULL slot: a grant loads the slot, a drained slot with no grant empties
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        last_d  = last_q;
        if (grant_valid) begin
            state_d = ST_FULL;
            resp_d  = '{id: grant_id, result: alu_result, ne: alu_isNotEqual,
                        lt: alu_isLessThan, ovf: alu_overflow};
            last_d  = grant_id;
        end else if (resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // state registers; last_grant resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            resp_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            last_q  <= last_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [STAT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // saturating per-requester grant counters
    always_comb begin
        cnt0_d = (req0_ready && cnt0_q != '1) ? cnt0_q + STAT_W'(1) : cnt0_q;
        cnt1_d = (req1_ready && cnt1_q != '1) ? cnt1_q + STAT_W'(1) : cnt1_q;
    end

    // counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign stat_grants0 = cnt0_q;
    assign stat_grants1 = cnt1_q;
`else
    assign stat_grants0 = '0;
    assign stat_grants1 = '0;
`endif

endmodule
